i2c_write_engine: RTL
=====================

Name: i2c_write_engine

Overview:
- Downstream I2C bit engine for the audio/video configuration sequencer.
- Accepts one 24-bit word {slave_addr, sub_addr, data} and a GO level from the sequencer, then runs a complete 3-byte I2C write: START, 27 bits (3 bytes plus 3 ACK slots), STOP.
- Reports completion and acknowledge status back to the sequencer.
- Runs on the system clock and generates the I2C bit timing internally from a quarter-period tick, so no divided clock domain is needed.

Parameters:
- CLK_Freq, 50000000: system clock frequency in Hz.
- I2C_Freq, 20000: SCL frequency in Hz.
- QDIV, CLK_Freq/(4*I2C_Freq): system clocks per SCL quarter-period. Derived, not overridden. Must be >= 2.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iDATA  in  24  [23:16] slave address+W, [15:8] sub-address, [7:0] data. Latched at start.
- iGO  in  1  level request from sequencer. A rising edge starts a transfer.
- oEND  out  1  transfer complete.
- oACK  out  1  1 = at least one NACK seen in the last transfer; 0 = all three bytes acknowledged.
- oBUSY  out  1  transfer in progress.
- I2C_SCLK  inout  1  I2C clock.
- I2C_SDAT  inout  1  I2C data, open-drain (drives 0 or Z only).

Behaviour:
- Reset (async, any time, including mid-transfer): state=IDLE, counters=0, SCL released high, SDA=Z, oEND=0, oACK=0, oBUSY=0. An aborted frame is not resumed.
- iGO is registered once; rising edge = iGO_q==0 && iGO==1. Edges are only honoured in IDLE and DONE, and ignored while oBUSY=1.
- On an accepted edge:
  - latch iDATA into shift register;
  - clear NACK flag and quarter counter;
  - set oBUSY=1, oEND=0;
  - go to START on the next clock.
- Quarter tick: counter counts 0..QDIV-1 while busy; tick when counter==QDIV-1.
- Each state below lasts four quarters q0..q3.
- START:
  - q0: SCL=1, SDA=Z.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA=0.
  - q3: SCL=0, SDA=0.
- BIT (index 0..26, MSB first per byte; indices 8, 17, 26 are ACK slots):
  - q0: SCL=0; SDA=0 if data bit is 0, else Z; ACK slots always Z.
  - q1: SCL=1.
  - q2: SCL=1; in ACK slots, sample SDA at the tick and set the NACK flag if the sample is 1.
  - q3: SCL=0.
- STOP:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA=0.
  - q3: SCL=1, SDA=Z.
- DONE, entered the clock after the STOP q3 tick:
  - oEND=1, oACK=NACK flag, oBUSY=0.
  - oEND stays high while iGO is high and drops the clock after iGO is sampled low; state then returns to IDLE.
  - If iGO is already low on DONE entry, oEND is high for exactly 1 clock.
  - oACK holds its value until the next accepted start.
- Latency: 116 quarters total (START 4, 27 bits × 4 = 108, STOP 4). oEND rises exactly 116*QDIV+2 clocks after the iGO rising edge is present at the input, without stretching.
- A NACK does not abort the frame: the full frame and STOP always complete.
- iGO falling mid-transfer: ignored. iDATA changing mid-transfer: ignored, because the data is latched.
- SCL and SDA change only on tick boundaries, so SDA never changes while SCL is high except at the START/STOP edges.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined:
  - I2C_SCLK is open-drain (0 or Z).
  - In every q1 where SCL is released, the quarter counter holds at 0 until I2C_SCLK reads 1 (slave clock stretching), then timing resumes.
  - Total latency is 116*QDIV+2 plus the stretch clocks.
- Undefined:
  - I2C_SCLK is driven push-pull 1/0 and never sampled.
  - Latency is fixed.

Test Plan (all with CLK_Freq=400, I2C_Freq=10, so QDIV=10):
- Reset, then iDATA=24'h341A0F, iGO rises, slave ACKs all bytes -> START seen; serialised bits equal 0x34, 0x1A, 0x0F; STOP seen; oEND rises at clock 1162 after the edge; oACK=0.
- Same transfer but slave NACKs the sub-address byte -> full 27 bits plus STOP still emitted; oEND=1, oACK=1.
- Hold iGO high through DONE, then drop it -> oEND stays 1 until 1 clock after iGO is sampled low; no second transfer starts. Raise iGO again -> new frame, previous oACK cleared.
- Pulse iGO twice while busy, and change iDATA to 24'h400000 mid-frame -> only one frame, carrying the originally latched 0x341A0F.
- Assert iRST_N low at bit 12 -> same clock: SDA=Z, SCL=1, oBUSY=0, oEND=0. After release, a new iGO edge gives a normal full frame.
- With I2C_CLK_STRETCH_EN: slave holds SCL low 37 clocks during bit 3 q1 -> bit timing resumes after release; oEND at 1162+37 clocks.

Source files
------------

// File: rtl/i2c_write_engine_if.sv
// Sequencer-side handshake of the I2C write engine: 24-bit word, GO level, and status.
interface i2c_write_engine_if;
    logic [23:0] iDATA;
    logic        iGO;
    logic        oEND;
    logic        oACK;
    logic        oBUSY;

    modport master (output iDATA, output iGO, input oEND, input oACK, input oBUSY);
    modport slave  (input iDATA, input iGO, output oEND, output oACK, output oBUSY);
endinterface

// File: rtl/i2c_write_engine.sv
// I2C 3-byte write engine: START, 27 bit slots (3 bytes + ACKs), STOP, timed by a quarter tick.
// Define I2C_CLK_STRETCH_EN for open-drain SCL with slave clock stretching in every q1.
module i2c_write_engine #(
    parameter int unsigned CLK_Freq = 50000000,
    parameter int unsigned I2C_Freq = 20000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    i2c_write_engine_if.slave seqBus,
    inout  wire               I2C_SCLK,
    inout  wire               I2C_SDAT
);
    // QDIV must come out >= 2 for the quarter counter to make sense.
    localparam int unsigned QDIV = CLK_Freq / (4 * I2C_Freq);
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StBit, StStop, StTail, StDone
    } stateT;

    stateT         stateQ, stateD;
    logic [QW-1:0] qCntQ, qCntD;
    logic [1:0]    quarterQ, quarterD;
    logic [4:0]    bitIdxQ, bitIdxD;
    logic [3:0]    slotQ, slotD;
    logic [23:0]   shiftQ, shiftD;
    logic          nackQ, nackD;
    logic          endQ, endD;
    logic          ackQ, ackD;
    logic          busyQ, busyD;
    logic          goQ;

    logic tick, rise, sdaIn, stretchHold, sclOut, sdaLow, inFrame;

    assign tick    = (qCntQ == QW'(QDIV - 1));
    assign rise    = !goQ && seqBus.iGO;
    assign sdaIn   = I2C_SDAT;
    assign inFrame = (stateQ == StStart) || (stateQ == StBit) || (stateQ == StStop);

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the quarter counter.
    assign stretchHold = inFrame && (quarterQ == 2'd1) && !I2C_SCLK;
    assign I2C_SCLK    = sclOut ? 1'bz : 1'b0;
`else
    assign stretchHold = 1'b0;
    assign I2C_SCLK    = sclOut;
`endif
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

    assign seqBus.oEND  = endQ;
    assign seqBus.oACK  = ackQ;
    assign seqBus.oBUSY = busyQ;

    always_comb begin
        sclOut = 1'b1;
        sdaLow = 1'b0;
        unique case (stateQ)
            StStart: begin
                sclOut = (quarterQ != 2'd3);
                sdaLow = (quarterQ != 2'd0);
            end
            StBit: begin
                sclOut = (quarterQ == 2'd1) || (quarterQ == 2'd2);
                sdaLow = (slotQ != 4'd8) && !shiftQ[23];
            end
            StStop: begin
                sclOut = (quarterQ != 2'd0);
                sdaLow = (quarterQ != 2'd3);
            end
            default: begin
                sclOut = 1'b1;
                sdaLow = 1'b0;
            end
        endcase
    end

    always_comb begin
        stateD   = stateQ;
        qCntD    = qCntQ;
        quarterD = quarterQ;
        bitIdxD  = bitIdxQ;
        slotD    = slotQ;
        shiftD   = shiftQ;
        nackD    = nackQ;
        endD     = endQ;
        ackD     = ackQ;
        busyD    = busyQ;
        unique case (stateQ)
            StIdle, StDone: begin
                if (rise) begin
                    shiftD = seqBus.iDATA;
                    nackD  = 1'b0;
                    qCntD  = '0;
                    busyD  = 1'b1;
                    endD   = 1'b0;
                    ackD   = 1'b0;
                    stateD = StLoad;
                end else if (stateQ == StDone && !seqBus.iGO) begin
                    endD   = 1'b0;
                    stateD = StIdle;
                end
            end
            StLoad: begin
                qCntD    = '0;
                quarterD = 2'd0;
                bitIdxD  = '0;
                slotD    = '0;
                stateD   = StStart;
            end
            StStart, StBit, StStop: begin
                if (stretchHold) begin
                    qCntD = '0;
                end else if (!tick) begin
                    qCntD = qCntQ + 1'b1;
                end else begin
                    qCntD    = '0;
                    quarterD = quarterQ + 2'd1;
                    if (stateQ == StBit && quarterQ == 2'd2 && slotQ == 4'd8 && sdaIn) begin
                        nackD = 1'b1;
                    end
                    if (quarterQ == 2'd3) begin
                        if (stateQ == StStart) begin
                            bitIdxD = '0;
                            slotD   = '0;
                            stateD  = StBit;
                        end else if (stateQ == StBit) begin
                            // Byte data shifts out MSB first; the ACK slot consumes no data.
                            if (slotQ == 4'd8) begin
                                slotD = '0;
                            end else begin
                                slotD  = slotQ + 4'd1;
                                shiftD = {shiftQ[22:0], 1'b0};
                            end
                            if (bitIdxQ == 5'd26) begin
                                stateD = StStop;
                            end else begin
                                bitIdxD = bitIdxQ + 5'd1;
                            end
                        end else begin
                            stateD = StTail;
                        end
                    end
                end
            end
            StTail: begin
                endD   = 1'b1;
                ackD   = nackQ;
                busyD  = 1'b0;
                stateD = StDone;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateQ   <= StIdle;
            qCntQ    <= '0;
            quarterQ <= '0;
            bitIdxQ  <= '0;
            slotQ    <= '0;
            shiftQ   <= '0;
            nackQ    <= 1'b0;
            endQ     <= 1'b0;
            ackQ     <= 1'b0;
            busyQ    <= 1'b0;
            goQ      <= 1'b0;
        end else begin
            stateQ   <= stateD;
            qCntQ    <= qCntD;
            quarterQ <= quarterD;
            bitIdxQ  <= bitIdxD;
            slotQ    <= slotD;
            shiftQ   <= shiftD;
            nackQ    <= nackD;
            endQ     <= endD;
            ackQ     <= ackD;
            busyQ    <= busyD;
            goQ      <= seqBus.iGO;
        end
    end
endmodule
